// File: rtl/round_key_sequencer_pkg.sv
// Shared constants, state encoding and GF(2^8) helper for the AES-128
// round-key sequencer and its key buffer.
package round_key_sequencer_pkg;

   localparam int RK_BUS_WIDTH  = 128;
   localparam int RK_NUM_ROUNDS = 10;
   localparam int RK_ADDR_WIDTH = 4;
   localparam int RK_LAST_INDEX = RK_NUM_ROUNDS;
   localparam int RK_NUM_KEYS   = RK_LAST_INDEX + 1;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] AES_REDUCE = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } seq_state_t;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_REDUCE : 8'h00);
   endfunction

endpackage

// File: rtl/round_key_buffer.sv
// Round-key storage: one write port, registered read port, reads beyond the
// last stored index return zero. Contents are intentionally not reset.
module round_key_buffer
   import round_key_sequencer_pkg::*;
#(
   parameter int BUS_WIDTH  = RK_BUS_WIDTH,
   parameter int ADDR_WIDTH = RK_ADDR_WIDTH,
   parameter int DEPTH      = RK_NUM_KEYS
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Wr_En_i,
   input  logic [ADDR_WIDTH-1:0] Wr_Addr_i,
   input  logic [BUS_WIDTH-1:0]  Wr_Data_i,
   input  logic [ADDR_WIDTH-1:0] Rd_Addr_i,
   output logic [BUS_WIDTH-1:0]  Rd_Data_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic [BUS_WIDTH-1:0] mem_q [DEPTH];
   logic [BUS_WIDTH-1:0] rd_data_q;

   always_ff @(posedge Clk) begin
      if (Wr_En_i && (Wr_Addr_i <= LAST_ADDR)) begin
         mem_q[Wr_Addr_i] <= Wr_Data_i;
      end
   end

   // Same-edge write and read of one index returns the previous contents.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         rd_data_q <= '0;
      end else if (Rd_Addr_i <= LAST_ADDR) begin
         rd_data_q <= mem_q[Rd_Addr_i];
      end else begin
         rd_data_q <= '0;
      end
   end

   assign Rd_Data_o = rd_data_q;

endmodule

// File: rtl/round_key_sequencer.sv
// Drives an external single-round key-schedule stage through NUM_ROUNDS
// iterations (issue, then capture) and stores round keys 0..NUM_ROUNDS.
module round_key_sequencer
   import round_key_sequencer_pkg::*;
#(
   parameter int BUS_WIDTH  = RK_BUS_WIDTH,
   parameter int NUM_ROUNDS = RK_NUM_ROUNDS,
   parameter int ADDR_WIDTH = RK_ADDR_WIDTH
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Start,
   input  logic [BUS_WIDTH-1:0]  Cipher_Key,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Keys_Ready,
   output logic [BUS_WIDTH-1:0]  Sched_Data_Raw,
   output logic [7:0]            Sched_Rcon,
   input  logic [BUS_WIDTH-1:0]  Sched_Key_New,
   input  logic [ADDR_WIDTH-1:0] Rk_Rd_Addr,
   output logic [BUS_WIDTH-1:0]  Rk_Rd_Data
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ROUND  = ADDR_WIDTH'(NUM_ROUNDS);
   localparam logic [ADDR_WIDTH-1:0] FIRST_ROUND = ADDR_WIDTH'(1);

   seq_state_t            state_q, state_d;
   logic [BUS_WIDTH-1:0]  cur_key_q, cur_key_d;
   logic [7:0]            rcon_q, rcon_d;
   logic [ADDR_WIDTH-1:0] round_q, round_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ready_q, ready_d;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [BUS_WIDTH-1:0]  wr_data;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= ST_IDLE;
         cur_key_q <= '0;
         rcon_q    <= 8'h00;
         round_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_key_q <= cur_key_d;
         rcon_q    <= rcon_d;
         round_q   <= round_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_key_d = cur_key_q;
      rcon_d    = rcon_q;
      round_d   = round_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ready_d   = ready_q;
      wr_en     = 1'b0;
      wr_addr   = round_q;
      wr_data   = Sched_Key_New;

      unique case (state_q)
         ST_IDLE: begin
            // Start is only honoured here, so requests while busy are dropped.
            if (Start) begin
               wr_en     = 1'b1;
               wr_addr   = '0;
               wr_data   = Cipher_Key;
               cur_key_d = Cipher_Key;
               rcon_d    = RCON_INIT;
               round_d   = FIRST_ROUND;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            wr_en     = 1'b1;
            cur_key_d = Sched_Key_New;
            rcon_d    = xtime(rcon_q);
            if (round_q == LAST_ROUND) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               round_d = round_q + FIRST_ROUND;
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stage inputs come straight from registers so they never glitch.
   assign Sched_Data_Raw = cur_key_q;
   assign Sched_Rcon     = rcon_q;
   assign Busy           = busy_q;
   assign Done           = done_q;
   assign Keys_Ready     = ready_q;

   round_key_buffer #(
      .BUS_WIDTH (BUS_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (NUM_ROUNDS + 1)
   ) u_buffer (
      .Clk      (Clk),
      .Rst      (Rst),
      .Wr_En_i  (wr_en),
      .Wr_Addr_i(wr_addr),
      .Wr_Data_i(wr_data),
      .Rd_Addr_i(Rk_Rd_Addr),
      .Rd_Data_o(Rk_Rd_Data)
   );

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer with a bench-owned key-schedule
// stage (XOR stub or behavioural AES-128 round) and a queue scoreboard.
module tb_round_key_sequencer;

   logic         Clk;
   logic         Rst;
   logic         Start;
   logic [127:0] Cipher_Key;
   logic         Busy;
   logic         Done;
   logic         Keys_Ready;
   logic [127:0] Sched_Data_Raw;
   logic [7:0]   Sched_Rcon;
   logic [127:0] Sched_Key_New;
   logic [3:0]   Rk_Rd_Addr;
   logic [127:0] Rk_Rd_Data;

   logic         use_aes;
   int           n_cmp;
   int           n_err;

   logic [7:0]   exp_rcon_q [$];
   logic [127:0] exp_raw_q  [$];
   logic [127:0] exp_rd_q   [$];
   logic [127:0] model_keys [11];

   localparam logic [7:0] RCON_TAB [10] =
      '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
   localparam logic [127:0] SEQ_KEY   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   localparam logic [127:0] SEQ_RK10  = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;
   // Zero key through the XOR stub: low byte is the XOR of all ten Rcons.
   localparam logic [127:0] STUB_RK10 = 128'h0000_0000_0000_0000_0000_0000_0000_00D2;

   round_key_sequencer dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Start         (Start),
      .Cipher_Key    (Cipher_Key),
      .Busy          (Busy),
      .Done          (Done),
      .Keys_Ready    (Keys_Ready),
      .Sched_Data_Raw(Sched_Data_Raw),
      .Sched_Rcon    (Sched_Rcon),
      .Sched_Key_New (Sched_Key_New),
      .Rk_Rd_Addr    (Rk_Rd_Addr),
      .Rk_Rd_Data    (Rk_Rd_Data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [7:0] gf_x(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = gf_x(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
         if (gf_mul(a, 8'(c)) == 8'h01) inv = 8'(c);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] stage_model(input logic [127:0] k,
                                                input logic [7:0] rc,
                                                input logic aes);
      logic [31:0] w0, w1, w2, w3, t;
      if (!aes) return k ^ {120'd0, rc};
      w0 = k[127:96];
      w1 = k[95:64];
      w2 = k[63:32];
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      t  = t ^ {rc, 24'd0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Registered key-schedule stage fed by the sequencer.
   always @(posedge Clk) begin
      Sched_Key_New <= stage_model(Sched_Data_Raw, Sched_Rcon, use_aes);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One expansion; optionally disturbed by Start pulses, chained onto a Done
   // cycle, or cut short by reset at cycle abort_at.
   task automatic expand(input logic [127:0] key, input bit disturb,
                         input bit chained, input int abort_at);
      logic [127:0] k;
      k = key;
      model_keys[0] = key;
      for (int r = 1; r <= 10; r++) begin
         exp_rcon_q.push_back(RCON_TAB[r-1]);
         exp_raw_q.push_back(k);
         k = stage_model(k, RCON_TAB[r-1], use_aes);
         model_keys[r] = k;
      end
      if (!chained) @(negedge Clk);
      Start      = 1'b1;
      Cipher_Key = key;
      Rk_Rd_Addr = 4'd3;
      for (int c = 1; c <= 20; c++) begin
         @(negedge Clk);
         Start      = disturb && (c == 5 || c == 12);
         Cipher_Key = Start ? ~key : key;
         if (c == abort_at) begin
            Rst = 1'b0;
            #1;
            check("abort_flags", {125'd0, Busy, Done, Keys_Ready}, 128'd0);
            check("abort_raw", Sched_Data_Raw, 128'd0);
            check("abort_rcon", {120'd0, Sched_Rcon}, 128'd0);
            check("abort_rd", Rk_Rd_Data, 128'd0);
            exp_rcon_q.delete();
            exp_raw_q.delete();
            $display("[%0t] expansion key=%h aborted by reset at cycle %0d", $time, key, c);
            return;
         end
         check($sformatf("busy_c%0d", c), {125'd0, Busy, Done, Keys_Ready}, 128'd4);
         if (c % 2 == 1) begin
            check($sformatf("rcon_c%0d", c), {120'd0, Sched_Rcon}, {120'd0, exp_rcon_q.pop_front()});
            check($sformatf("raw_c%0d", c), Sched_Data_Raw, exp_raw_q.pop_front());
         end
         if (c >= 9) check($sformatf("rd3_noX_c%0d", c), {127'd0, $isunknown(Rk_Rd_Data)}, 128'd0);
      end
      @(negedge Clk);
      Start = 1'b0;
      check("done_cycle", {125'd0, Busy, Done, Keys_Ready}, 128'd3);
      $display("[%0t] expansion key=%h finished", $time, key);
   endtask

   // Pipelined read-back of indices 0..15; also confirms Done was one cycle.
   task automatic read_keys(input string tag);
      for (int a = 0; a <= 16; a++) begin
         @(negedge Clk);
         check("idle_flags", {125'd0, Busy, Done, Keys_Ready}, 128'd1);
         if (exp_rd_q.size() > 0) check($sformatf("%s_a%0d", tag, a - 1), Rk_Rd_Data, exp_rd_q.pop_front());
         if (a < 16) begin
            Rk_Rd_Addr = 4'(a);
            exp_rd_q.push_back((a <= 10) ? model_keys[a] : 128'd0);
         end
      end
      $display("[%0t] read-back %s complete", $time, tag);
   endtask

   task automatic read_one(input logic [3:0] addr, input logic [127:0] exp, input string tag);
      @(negedge Clk);
      Rk_Rd_Addr = addr;
      exp_rd_q.push_back(exp);
      @(negedge Clk);
      check(tag, Rk_Rd_Data, exp_rd_q.pop_front());
      $display("[%0t] read addr=%0d data=%h", $time, addr, Rk_Rd_Data);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      use_aes    = 1'b0;
      Rst        = 1'b0;
      Start      = 1'b0;
      Cipher_Key = '0;
      Rk_Rd_Addr = '0;
      repeat (3) @(negedge Clk);
      check("reset_flags", {125'd0, Busy, Done, Keys_Ready}, 128'd0);
      check("reset_raw", Sched_Data_Raw, 128'd0);
      check("reset_rcon", {120'd0, Sched_Rcon}, 128'd0);
      check("reset_rd", Rk_Rd_Data, 128'd0);
      Rst = 1'b1;

      // XOR stub, zero key: Rcon sequence, 20-cycle latency, accumulated Rcons.
      expand(128'd0, 1'b0, 1'b0, 0);
      read_keys("stub");
      read_one(4'd10, STUB_RK10, "stub_rk10");

      // Same run with ignored Start pulses at cycles 5 and 12.
      expand(128'd0, 1'b1, 1'b0, 0);
      read_keys("stub_disturbed");
      read_one(4'd10, STUB_RK10, "stub_disturbed_rk10");

      // Behavioural AES round stage, FIPS-197 key.
      use_aes = 1'b1;
      expand(FIPS_KEY, 1'b0, 1'b0, 0);
      read_keys("fips");
      read_one(4'd10, FIPS_RK10, "fips_rk10");
      read_one(4'd0, FIPS_KEY, "fips_rk0");
      read_one(4'd11, 128'd0, "oob_11");
      read_one(4'd15, 128'd0, "oob_15");

      // Start in the Done cycle is accepted as a new expansion.
      expand(FIPS_KEY, 1'b0, 1'b0, 0);
      expand(SEQ_KEY, 1'b0, 1'b1, 0);
      read_keys("chained");
      read_one(4'd10, SEQ_RK10, "chained_rk10");

      // Reset mid-expansion, then a clean run.
      expand(SEQ_KEY, 1'b0, 1'b0, 9);
      @(negedge Clk);
      check("held_reset_flags", {125'd0, Busy, Done, Keys_Ready}, 128'd0);
      Rst = 1'b1;
      expand(FIPS_KEY, 1'b0, 1'b0, 0);
      read_keys("after_reset");
      read_one(4'd10, FIPS_RK10, "after_reset_rk10");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
